// File: rtl/l2_request_issuer_if.sv
// l2_arbitration_interface: request/grant handshake between L2 requesters and the round-robin arbiter
interface l2_arbitration_interface #(
  parameter int NUM_PORTS = 4,
  parameter int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
);
  logic [NUM_PORTS-1:0] requests;
  logic                 strobe;
  logic                 grantee_valid;
  logic [NUM_PORTS-1:0] grantee_v;
  logic [PW-1:0]        grantee_i;
  modport master (output requests, strobe, input grantee_valid, grantee_v, grantee_i);
  modport slave (input requests, strobe, output grantee_valid, grantee_v, grantee_i);
endinterface

// File: rtl/l2_request_issuer.sv
// l2_request_issuer: per-port request queues feeding one arbitrated, registered output stage
module l2_request_issuer #(
  parameter int NUM_PORTS = 4,
  parameter int ADDR_W = 30,
  parameter int DATA_W = 32,
  parameter int QUEUE_DEPTH = 2,
  parameter int PW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_PORTS-1:0]        in_valid,
  output logic [NUM_PORTS-1:0]        in_ready,
  input  logic [NUM_PORTS*ADDR_W-1:0] in_addr,
  input  logic [NUM_PORTS-1:0]        in_rnw,
  input  logic [NUM_PORTS*4-1:0]      in_be,
  input  logic [NUM_PORTS*DATA_W-1:0] in_wdata,
  l2_arbitration_interface.master     arb,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [PW-1:0]               out_port,
  output logic [ADDR_W-1:0]           out_addr,
  output logic                        out_rnw,
  output logic [3:0]                  out_be,
  output logic [DATA_W-1:0]           out_wdata
);
  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int EW = ADDR_W + 1 + 4 + DATA_W;
  logic [NUM_PORTS-1:0]         nonempty;
  logic [NUM_PORTS-1:0][EW-1:0] heads;
  logic                         load_en;
  logic                         strobe;
  logic                         unused_grantee_v;
  assign load_en = ~out_valid | out_ready;
  assign strobe = arb.grantee_valid & load_en;
  assign arb.strobe = strobe;
  assign arb.requests = nonempty;
  assign unused_grantee_v = ^arb.grantee_v;
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_q
    logic [EW-1:0] mem [QUEUE_DEPTH];
    logic [QW-1:0] wr_ptr, rd_ptr;
    logic [QW:0]   cnt;
    logic          push, pop;
    assign nonempty[p] = cnt != '0;
    assign in_ready[p] = cnt != (QW+1)'(QUEUE_DEPTH);
    assign push = in_valid[p] & in_ready[p];
    assign pop = strobe & (arb.grantee_i == PW'(p));
    assign heads[p] = mem[rd_ptr];
    always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= {in_addr[p*ADDR_W +: ADDR_W], in_rnw[p], in_be[p*4 +: 4], in_wdata[p*DATA_W +: DATA_W]};
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        cnt <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + QW'(1);
        if (pop) rd_ptr <= rd_ptr + QW'(1);
        cnt <= cnt + (QW+1)'(push) - (QW+1)'(pop);
      end
    assert property (@(posedge clk) disable iff (rst) pop |-> nonempty[p]);
    assert property (@(posedge clk) disable iff (rst) push |-> cnt != (QW+1)'(QUEUE_DEPTH));
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      out_valid <= 1'b0;
      out_port <= '0;
      {out_addr, out_rnw, out_be, out_wdata} <= '0;
    end else if (strobe) begin
      out_valid <= 1'b1;
      out_port <= arb.grantee_i;
      {out_addr, out_rnw, out_be, out_wdata} <= heads[arb.grantee_i];
    end else if (out_ready) out_valid <= 1'b0;
  assert property (@(posedge clk) disable iff (rst) strobe |-> arb.requests[arb.grantee_i]);
endmodule

// File: tb/tb_l2_request_issuer.sv
// tb_l2_request_issuer: random and directed traffic checked against a queue-level reference model
module tb_l2_request_issuer;
  typedef struct packed {
    logic [29:0] addr;
    logic        rnw;
    logic [3:0]  be;
    logic [31:0] wdata;
  } req_t;
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [3:0]   in_valid = '0;
  logic [3:0]   in_ready;
  logic [119:0] in_addr = '0;
  logic [3:0]   in_rnw = '0;
  logic [15:0]  in_be = '0;
  logic [127:0] in_wdata = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [1:0]   out_port;
  logic [29:0]  out_addr;
  logic         out_rnw;
  logic [3:0]   out_be;
  logic [31:0]  out_wdata;
  always #5 clk = ~clk;
  l2_arbitration_interface #(.NUM_PORTS(4)) arb ();
  l2_request_issuer dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_addr(in_addr),
    .in_rnw(in_rnw), .in_be(in_be), .in_wdata(in_wdata), .arb(arb), .out_valid(out_valid),
    .out_ready(out_ready), .out_port(out_port), .out_addr(out_addr), .out_rnw(out_rnw),
    .out_be(out_be), .out_wdata(out_wdata)
  );
  // round-robin arbiter stand-in; priority starts at port 3 after reset
  logic [1:0] rr, gi;
  always_comb begin
    gi = rr;
    for (int k = 3; k >= 0; k--) if (arb.requests[rr + 2'(k)]) gi = rr + 2'(k);
  end
  assign arb.grantee_valid = |arb.requests;
  assign arb.grantee_i = gi;
  assign arb.grantee_v = arb.grantee_valid ? 4'(1) << gi : 4'd0;
  always_ff @(posedge clk or posedge rst)
    if (rst) rr <= 2'd3;
    else if (arb.strobe) rr <= gi + 2'd1;
  int dut_str = 0;
  always @(posedge clk) if (!rst && arb.strobe) dut_str <= dut_str + 1;
  int n_chk = 0, n_fail = 0;
  req_t mq[4][$];
  req_t m_out;
  logic m_ov;
  logic [1:0] m_port;
  int glog[$];
  logic [3:0] acc_last;
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic req_t mk(input logic [29:0] a, input logic r, input logic [3:0] b, input logic [31:0] w);
    mk = '{addr: a, rnw: r, be: b, wdata: w};
  endfunction
  function automatic req_t rnd();
    rnd = mk(30'($urandom), 1'($urandom), 4'($urandom), $urandom);
  endfunction
  task automatic drive(input int p, input logic v, input req_t r);
    in_valid[p] = v;
    in_addr[p*30 +: 30] = r.addr;
    in_rnw[p] = r.rnw;
    in_be[p*4 +: 4] = r.be;
    in_wdata[p*32 +: 32] = r.wdata;
  endtask
  task automatic model_reset();
    for (int p = 0; p < 4; p++) mq[p].delete();
    m_out = '0;
    m_ov = 1'b0;
    m_port = 2'd0;
  endtask
  task automatic check_outputs();
    for (int p = 0; p < 4; p++) begin
      chk("in_ready", in_ready[p], mq[p].size() < 2);
      chk("requests", arb.requests[p], mq[p].size() != 0);
    end
    chk("out_valid", out_valid, m_ov);
    chk("out_port", out_port, m_port);
    chk("out_fields", {out_addr, out_rnw, out_be, out_wdata}, m_out);
  endtask
  // one cycle: check the state left by the last edge, then advance the model across the next edge
  task automatic step();
    logic any, st;
    int g;
    #1 check_outputs();
    any = 1'b0;
    for (int p = 0; p < 4; p++) any |= mq[p].size() != 0;
    st = any && (!m_ov || out_ready);
    chk("strobe", arb.strobe, st);
    for (int p = 0; p < 4; p++) acc_last[p] = in_valid[p] && mq[p].size() < 2;
    if (st) begin
      g = int'(arb.grantee_i);
      glog.push_back(g);
      if (mq[g].size() != 0) m_out = mq[g].pop_front();
      m_port = 2'(g);
      m_ov = 1'b1;
    end else if (out_ready) m_ov = 1'b0;
    for (int p = 0; p < 4; p++)
      if (acc_last[p]) mq[p].push_back(mk(in_addr[p*30 +: 30], in_rnw[p], in_be[p*4 +: 4], in_wdata[p*32 +: 32]));
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    int d0, base, n;
    int exp_seq[4] = '{3, 0, 1, 2};
    model_reset();
    @(negedge clk);
    #1 check_outputs();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    d0 = dut_str;
    drive(2, 1'b1, mk(30'h100, 1'b0, 4'hF, 32'hDEADBEEF));
    step();
    in_valid = '0;
    repeat (3) step();
    chk("t1_strobes", dut_str - d0, 1);
    chk("t1_port", glog[glog.size()-1], 2);
    base = glog.size();
    for (int p = 0; p < 4; p++) drive(p, 1'b1, mk(30'h1000 + 30'(p), 1'b1, 4'h0, 32'(p)));
    step();
    in_valid = '0;
    repeat (5) step();
    for (int k = 0; k < 4; k++) chk("rr_order", glog[base+k], exp_seq[k]);
    out_ready = 1'b0;
    n = 0;
    d0 = dut_str;
    for (int c = 0; c < 6; c++) begin
      drive(0, 1'b1, mk(30'h200 + 30'(n), 1'b1, 4'h1, 32'(n)));
      step();
      if (acc_last[0]) n++;
    end
    chk("bp_accepted", n, 3);
    chk("bp_full", in_ready[0], 1'b0);
    chk("bp_strobe", arb.strobe, 1'b0);
    in_valid = '0;
    out_ready = 1'b1;
    repeat (5) step();
    chk("bp_delivered", dut_str - d0, 3);
    for (int c = 0; c < 8; c++) begin
      drive(1, 1'b1, mk(30'h300 + 30'(c), 1'b0, 4'(c), 32'hA000 + 32'(c)));
      step();
    end
    in_valid = '0;
    repeat (3) step();
    out_ready = 1'b0;
    drive(0, 1'b1, rnd());
    drive(3, 1'b1, rnd());
    step();
    in_valid = '0;
    drive(1, 1'b1, rnd());
    step();
    in_valid = '0;
    chk("pre_arst_valid", out_valid, 1'b1);
    #3 rst = 1'b1;
    #1;
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_requests", arb.requests, 4'h0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (4) step();
    for (int c = 0; c < 10000; c++) begin
      for (int p = 0; p < 4; p++) drive(p, 1'($urandom_range(0, 1)), rnd());
      out_ready = $urandom_range(0, 3) != 0;
      step();
    end
    in_valid = '0;
    out_ready = 1'b1;
    repeat (12) step();
    chk("drain_requests", arb.requests, 4'h0);
    chk("drain_out_valid", out_valid, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
